// File: rtl/mic_ring_dma.sv
// mic_ring_dma: multi-channel microphone-to-SDRAM DMA writer.
//
// Each SAMPLE_VALID frame walks channels 0..NUM_CH-1. For every channel it
// steers the capture mux (SEL), waits one cycle for the mux to settle, then
// captures MIC_DATA and issues one single-beat Avalon-MM write. Channel ch
// owns the region starting at BASE + ch*REGION_WORDS*4. All channels share
// one word index. The index advances once per complete frame. A region is
// either filled linearly (then stop) or used as a ring buffer.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   AM_*              Avalon-MM write master (single beat, full word)
//   MIC_DATA, SEL     capture mux data in / channel select out
//   SAMPLE_VALID      one-cycle pulse per available frame
//   START             level: high arms a run, low requests a stop
//   BASE_ADDR         region 0 byte base, latched when arming
//   HALF_ACK/FULL_ACK clear the matching sticky event
//   HALF_EVT/FULL_EVT sticky half-region / region-end events
//   OVERRUN           sticky: a frame arrived while a frame was in flight
//   WR_INDEX          current word index within the regions
//   BUSY, FINISHED    run status
module mic_ring_dma #(
  parameter int unsigned NUM_CH       = 5,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned REGION_WORDS = 1920000,
  parameter int unsigned CIRCULAR     = 0,
  localparam int unsigned SelW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] AM_ADDR,
  output logic [2:0]        AM_BURSTCOUNT,
  output logic              AM_WRITE,
  output logic [31:0]       AM_WRITEDATA,
  output logic [3:0]        AM_BYTEENABLE,
  input  logic              AM_WAITREQUEST,
  input  logic [31:0]       MIC_DATA,
  output logic [SelW-1:0]   SEL,
  input  logic              SAMPLE_VALID,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              HALF_ACK,
  input  logic              FULL_ACK,
  output logic              HALF_EVT,
  output logic              FULL_EVT,
  output logic              OVERRUN,
  output logic [31:0]       WR_INDEX,
  output logic              BUSY,
  output logic              FINISHED
);

  localparam int unsigned IdxW = $clog2(REGION_WORDS + 1);

  localparam logic [SelW-1:0]   LastCh      = SelW'(NUM_CH - 1);
  localparam logic [IdxW-1:0]   HalfIdx     = IdxW'(REGION_WORDS / 2);
  localparam logic [IdxW-1:0]   FullIdx     = IdxW'(REGION_WORDS);
  // Region stride in bytes, computed in ADDR_W bits so overflow wraps.
  localparam logic [ADDR_W-1:0] RegionBytes = ADDR_W'(REGION_WORDS) << 2;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StSel,
    StWr,
    StAdv,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   ch_q, ch_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              half_q, half_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;

  logic              busy;
  logic [IdxW-1:0]   idx_inc;
  logic [ADDR_W-1:0] ch_off;
  logic [ADDR_W-1:0] idx_off;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      ch_q    <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      half_q  <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      half_q  <= half_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy    = (state_q != StIdle) && (state_q != StFin);
  assign idx_inc = idx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    // Acks clear first; a set later in this block overrides (set wins).
    half_d  = half_q & ~HALF_ACK;
    full_d  = full_q & ~FULL_ACK;
    ovr_d   = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (START) state_d = StArm;
      end
      StArm: begin
        base_d  = BASE_ADDR;
        idx_d   = '0;
        ch_d    = '0;
        ovr_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        // A stop request wins over a frame arriving in the same cycle,
        // so a stop never starts a new frame.
        if (!START) begin
          state_d = StFin;
        end else if (SAMPLE_VALID) begin
          ch_d    = '0;
          state_d = StSel;
        end
      end
      StSel: begin
        // SEL has been stable for this whole cycle, so the mux output is settled.
        wdata_d = MIC_DATA;
        state_d = StWr;
      end
      StWr: begin
        if (!AM_WAITREQUEST) begin
          if (ch_q == LastCh) begin
            state_d = StAdv;
          end else begin
            ch_d    = ch_q + SelW'(1);
            state_d = StSel;
          end
        end
      end
      StAdv: begin
        idx_d   = idx_inc;
        state_d = START ? StWait : StFin;
        if (idx_inc == HalfIdx) half_d = 1'b1;
        if (idx_inc == FullIdx) begin
          full_d = 1'b1;
          if (CIRCULAR != 0) begin
            idx_d = '0;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        if (!START) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A frame that arrives mid-frame is dropped and flagged. It is also flagged
    // during arming, where the set takes priority over the clear.
    if (SAMPLE_VALID && busy && (state_q != StWait)) ovr_d = 1'b1;
  end

  assign ch_off  = ADDR_W'(ch_q) * RegionBytes;
  assign idx_off = ADDR_W'(idx_q) << 2;

  // Address and data come from registers only, so they stay stable while the
  // slave stalls.
  assign AM_ADDR       = base_q + ch_off + idx_off;
  assign AM_BURSTCOUNT = 3'd1;
  assign AM_WRITE      = (state_q == StWr);
  assign AM_WRITEDATA  = wdata_q;
  assign AM_BYTEENABLE = 4'hF;
  assign SEL           = ch_q;
  assign HALF_EVT      = half_q;
  assign FULL_EVT      = full_q;
  assign OVERRUN       = ovr_q;
  assign WR_INDEX      = 32'(idx_q);
  assign BUSY          = busy;
  assign FINISHED      = (state_q == StFin);

endmodule

// File: tb/tb_mic_ring_dma.sv
// Bench for mic_ring_dma: a linear and a circular instance (NUM_CH=3,
// REGION_WORDS=8) share stimulus. A frame-level reference model predicts the
// write stream and the flags of each instance.
module tb_mic_ring_dma;

  localparam int NCH = 3;
  localparam int RW  = 8;

  logic        clk, reset, start, sv, half_ack, full_ack, waitreq;
  logic [31:0] base;
  logic [31:0] mic_vals [4];
  logic [31:0] mic_l, mic_c;

  logic [31:0] l_addr, l_wdata, l_widx, c_addr, c_wdata, c_widx;
  logic [2:0]  l_burst, c_burst;
  logic [3:0]  l_be, c_be;
  logic [1:0]  l_sel, c_sel;
  logic        l_write, l_half, l_full, l_ovr, l_busy, l_fin;
  logic        c_write, c_half, c_full, c_ovr, c_busy, c_fin;

  assign mic_l = mic_vals[l_sel];
  assign mic_c = mic_vals[c_sel];

  mic_ring_dma #(.NUM_CH(NCH), .ADDR_W(32), .REGION_WORDS(RW), .CIRCULAR(0)) u_dut_lin (
    .CLK(clk), .RESET(reset), .AM_ADDR(l_addr), .AM_BURSTCOUNT(l_burst), .AM_WRITE(l_write),
    .AM_WRITEDATA(l_wdata), .AM_BYTEENABLE(l_be), .AM_WAITREQUEST(waitreq), .MIC_DATA(mic_l),
    .SEL(l_sel), .SAMPLE_VALID(sv), .START(start), .BASE_ADDR(base), .HALF_ACK(half_ack),
    .FULL_ACK(full_ack), .HALF_EVT(l_half), .FULL_EVT(l_full), .OVERRUN(l_ovr),
    .WR_INDEX(l_widx), .BUSY(l_busy), .FINISHED(l_fin)
  );

  mic_ring_dma #(.NUM_CH(NCH), .ADDR_W(32), .REGION_WORDS(RW), .CIRCULAR(1)) u_dut_cir (
    .CLK(clk), .RESET(reset), .AM_ADDR(c_addr), .AM_BURSTCOUNT(c_burst), .AM_WRITE(c_write),
    .AM_WRITEDATA(c_wdata), .AM_BYTEENABLE(c_be), .AM_WAITREQUEST(waitreq), .MIC_DATA(mic_c),
    .SEL(c_sel), .SAMPLE_VALID(sv), .START(start), .BASE_ADDR(base), .HALF_ACK(half_ack),
    .FULL_ACK(full_ack), .HALF_EVT(c_half), .FULL_EVT(c_full), .OVERRUN(c_ovr),
    .WR_INDEX(c_widx), .BUSY(c_busy), .FINISHED(c_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed and predicted transfers, {addr, data}.
  logic [63:0] mon_l[$], mon_c[$], exp_l[$], exp_c[$];

  // Frame-level reference model, index 0 = linear, 1 = circular.
  bit          running [2];
  int          idx_m   [2];
  bit          half_m  [2];
  bit          full_m  [2];
  bit          ovr_m   [2];
  bit          fin_m   [2];
  logic [31:0] base_m;

  // A transfer completes on the edge after a cycle with write high and no stall.
  always @(negedge clk) begin
    if (l_write && !waitreq) mon_l.push_back({l_addr, l_wdata});
    if (c_write && !waitreq) mon_c.push_back({c_addr, c_wdata});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      running[d] = 0; idx_m[d] = 0; half_m[d] = 0; full_m[d] = 0; ovr_m[d] = 0; fin_m[d] = 0;
    end
    base_m = '0;
  endfunction

  // One accepted frame: NCH writes at the current index, then advance.
  function automatic void model_frame(input int d, input bit sv_mid, input bit ack_adv,
                                      input bit s_end);
    logic [63:0] w;
    if (!running[d]) begin
      if (ack_adv) full_m[d] = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      w = {base_m + 32'(c * RW * 4) + 32'(idx_m[d] * 4), mic_vals[c]};
      if (d == 0) exp_l.push_back(w);
      else exp_c.push_back(w);
    end
    if (sv_mid) ovr_m[d] = 1;
    idx_m[d]++;
    if (ack_adv) full_m[d] = 0;
    if (idx_m[d] == RW / 2) half_m[d] = 1;
    if (idx_m[d] == RW) begin
      full_m[d] = 1;
      if (d == 1) begin
        idx_m[d] = 0;
      end else begin
        running[d] = 0;
        fin_m[d] = 1;
      end
    end
    if (!s_end && running[d]) begin
      running[d] = 0;
      fin_m[d] = 1;
    end
  endfunction

  task automatic arm(input logic [31:0] b);
    start = 0; tick; tick;
    base = b; start = 1; tick; tick;
    base_m = b;
    for (int d = 0; d < 2; d++) begin
      running[d] = 1; idx_m[d] = 0; ovr_m[d] = 0; fin_m[d] = 0;
    end
  endtask

  task automatic ack_pulse(input bit h, input bit f);
    half_ack = h; full_ack = f; tick; half_ack = 0; full_ack = 0;
    for (int d = 0; d < 2; d++) begin
      if (h) half_m[d] = 0;
      if (f) full_m[d] = 0;
    end
  endtask

  // stall_ch >= NCH means no stall.
  task automatic run_frame(input int stall_ch, input int stall_n, input bit sv_mid,
                           input bit ack_adv, input bit drop_start);
    logic [31:0] ha, hd;
    bit s_end;
    for (int c = 0; c < NCH; c++) mic_vals[c] = $urandom;
    s_end = drop_start ? 1'b0 : start;
    for (int d = 0; d < 2; d++) model_frame(d, sv_mid, ack_adv, s_end);
    sv = 1; tick; sv = 0;
    for (int c = 0; c < NCH; c++) begin
      tick;
      if (c == stall_ch) begin
        waitreq = 1; ha = c_addr; hd = c_wdata;
        repeat (stall_n) begin
          tick;
          chk("stall_addr", c_addr, ha);
          chk("stall_data", c_wdata, hd);
          chk1("stall_write", c_write, 1'b1);
        end
        waitreq = 0;
      end
      if (sv_mid && c == 1) sv = 1;
      if (drop_start && c == 1) start = 0;
      tick;
      sv = 0;
    end
    if (ack_adv) full_ack = 1;
    tick;
    full_ack = 0;
  endtask

  task automatic compare_q(input string tag);
    logic [63:0] a, e;
    chk({tag, "_nwr_lin"}, 32'(mon_l.size()), 32'(exp_l.size()));
    while (mon_l.size() > 0 && exp_l.size() > 0) begin
      a = mon_l.pop_front(); e = exp_l.pop_front();
      chk({tag, "_addr_lin"}, a[63:32], e[63:32]);
      chk({tag, "_data_lin"}, a[31:0], e[31:0]);
    end
    chk({tag, "_nwr_cir"}, 32'(mon_c.size()), 32'(exp_c.size()));
    while (mon_c.size() > 0 && exp_c.size() > 0) begin
      a = mon_c.pop_front(); e = exp_c.pop_front();
      chk({tag, "_addr_cir"}, a[63:32], e[63:32]);
      chk({tag, "_data_cir"}, a[31:0], e[31:0]);
    end
    mon_l.delete(); exp_l.delete(); mon_c.delete(); exp_c.delete();
  endtask

  task automatic check_dut(input int d, input string tag, input logic [31:0] widx,
                           input logic half, input logic full, input logic ovr,
                           input logic fin, input logic busy);
    string n;
    n = (d == 0) ? {tag, "_lin"} : {tag, "_cir"};
    chk({n, "_idx"}, widx, 32'(idx_m[d]));
    chk1({n, "_half"}, half, half_m[d]);
    chk1({n, "_full"}, full, full_m[d]);
    chk1({n, "_ovr"}, ovr, ovr_m[d]);
    chk1({n, "_fin"}, fin, fin_m[d]);
    chk1({n, "_busy"}, busy, running[d]);
  endtask

  task automatic check_models(input string tag);
    check_dut(0, tag, l_widx, l_half, l_full, l_ovr, l_fin, l_busy);
    check_dut(1, tag, c_widx, c_half, c_full, c_ovr, c_fin, c_busy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, l_addr | c_addr, 32'h0);
    chk({tag, "_data"}, l_wdata | c_wdata, 32'h0);
    chk({tag, "_idx"}, l_widx | c_widx, 32'h0);
    chk({tag, "_sel"}, {30'b0, l_sel | c_sel}, 32'h0);
    chk({tag, "_flags"}, {20'b0, l_write, c_write, l_half, c_half, l_full, c_full,
                          l_ovr, c_ovr, l_busy, c_busy, l_fin, c_fin}, 32'h0);
    chk({tag, "_burst"}, {29'b0, l_burst & c_burst}, 32'h1);
    chk({tag, "_be"}, {28'b0, l_be & c_be}, 32'hF);
  endtask

  typedef struct {
    int          stall_ch;
    int          stall_n;
    bit          sv_mid;
    bit          ack_adv;
    int          l_writes;
    int          l_idx;
    bit          l_half;
    bit          l_full;
    bit          l_fin;
    int          c_writes;
    int          c_idx;
    bit          c_full;
    bit          c_ovr;
    logic [31:0] c_first;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] fa;
    string       t;
    int          sc, sn;
    bit          sm, aa, ha, fb;

    vecs[0] = '{3, 0, 0, 0, 3, 1, 0, 0, 0, 3, 1, 0, 0, 32'h1000};
    vecs[1] = '{1, 4, 0, 0, 3, 2, 0, 0, 0, 3, 2, 0, 0, 32'h1004};
    vecs[2] = '{3, 0, 1, 0, 3, 3, 0, 0, 0, 3, 3, 0, 1, 32'h1008};
    vecs[3] = '{0, 2, 0, 0, 3, 4, 1, 0, 0, 3, 4, 0, 1, 32'h100C};
    vecs[4] = '{2, 1, 0, 0, 3, 5, 1, 0, 0, 3, 5, 0, 1, 32'h1010};
    vecs[5] = '{3, 0, 0, 0, 3, 6, 1, 0, 0, 3, 6, 0, 1, 32'h1014};
    vecs[6] = '{3, 0, 0, 0, 3, 7, 1, 0, 0, 3, 7, 0, 1, 32'h1018};
    vecs[7] = '{3, 0, 0, 1, 3, 8, 1, 1, 1, 3, 0, 1, 1, 32'h101C};
    vecs[8] = '{3, 0, 0, 0, 0, 8, 1, 1, 1, 3, 1, 1, 1, 32'h1000};

    for (int i = 0; i < 4; i++) mic_vals[i] = '0;
    reset = 1; start = 0; sv = 0; half_ack = 0; full_ack = 0; waitreq = 0; base = '0;
    model_reset();
    tick; tick;
    reset = 0;
    tick;
    check_zero("reset");
    mon_l.delete(); mon_c.delete();

    arm(32'h1000);
    for (int i = 0; i < 9; i++) begin
      t = $sformatf("frame%0d", i + 1);
      run_frame(vecs[i].stall_ch, vecs[i].stall_n, vecs[i].sv_mid, vecs[i].ack_adv, 0);
      chk({t, "_lin_nwr"}, 32'(mon_l.size()), 32'(vecs[i].l_writes));
      chk({t, "_lin_idx"}, l_widx, 32'(vecs[i].l_idx));
      chk1({t, "_lin_half"}, l_half, vecs[i].l_half);
      chk1({t, "_lin_full"}, l_full, vecs[i].l_full);
      chk1({t, "_lin_fin"}, l_fin, vecs[i].l_fin);
      chk({t, "_cir_nwr"}, 32'(mon_c.size()), 32'(vecs[i].c_writes));
      chk({t, "_cir_idx"}, c_widx, 32'(vecs[i].c_idx));
      chk1({t, "_cir_full"}, c_full, vecs[i].c_full);
      chk1({t, "_cir_ovr"}, c_ovr, vecs[i].c_ovr);
      fa = (mon_c.size() > 0) ? mon_c[0][63:32] : 32'hDEAD_BEEF;
      chk({t, "_cir_first_addr"}, fa, vecs[i].c_first);
      compare_q(t);
    end

    // Stop, then re-arm: overrun clears, events persist.
    start = 0; tick;
    chk1("stop_cir_fin", c_fin, 1'b1);
    chk1("stop_lin_idle", l_fin, 1'b0);
    tick;
    chk1("stop_cir_idle", c_fin, 1'b0);
    base = 32'h1000; start = 1; tick;
    chk1("arm_busy", c_busy, 1'b1);
    tick;
    for (int d = 0; d < 2; d++) begin
      running[d] = 1; idx_m[d] = 0; ovr_m[d] = 0; fin_m[d] = 0;
    end
    check_models("rearm");

    ack_pulse(1, 0);
    check_models("half_ack");
    ack_pulse(0, 1);
    check_models("full_ack");

    // Stop requested mid-frame: the frame still completes, then FIN.
    run_frame(3, 0, 0, 0, 1);
    check_models("stopmid");
    compare_q("stopmid");
    tick;
    chk1("stopmid_idle", l_fin | c_fin, 1'b0);
    fin_m[0] = 0; fin_m[1] = 0;

    // Reset during a stalled write.
    arm(32'h2000);
    for (int c = 0; c < NCH; c++) mic_vals[c] = $urandom;
    sv = 1; tick; sv = 0; tick;
    waitreq = 1; tick;
    chk1("rst_pre_write", c_write, 1'b1);
    reset = 1; tick;
    check_zero("rst_mid");
    reset = 0;
    model_reset();
    repeat (3) begin
      tick;
      chk1("rst_no_write", l_write | c_write, 1'b0);
    end
    waitreq = 0;
    chk("rst_nwr", 32'(mon_l.size() + mon_c.size()), 32'h0);
    mon_l.delete(); mon_c.delete();

    // Randomised frames against the model, base near the top of memory.
    arm(($urandom | 32'hFFFF_FF00) & 32'hFFFF_FFFC);
    for (int f = 0; f < 20; f++) begin
      sc = $urandom_range(0, 3);
      sn = $urandom_range(1, 3);
      sm = ($urandom_range(0, 3) == 0);
      aa = ($urandom_range(0, 4) == 0);
      t = $sformatf("rnd%0d", f);
      run_frame(sc, sn, sm, aa, 0);
      check_models(t);
      compare_q(t);
      if ($urandom_range(0, 2) == 0) begin
        ha = $urandom_range(0, 1);
        fb = $urandom_range(0, 1);
        ack_pulse(ha, fb);
        check_models({t, "_ack"});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
